// File: rtl/mau_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mau_pkg : shared types, encodings and alignment checks for MAU   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mau_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    function automatic logic f3_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        case (f3)
            F3_H, F3_HU: bad = off[0];
            F3_W:        bad = (off != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mau_align : store lane replication/strobes, load extract/extend  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mau_align
    import mau_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        wdata_o = wdata_i;
        wstrb_o = 4'b1111;
        case (funct3_i[1:0])
            2'b00: begin
                wdata_o = {4{wdata_i[7:0]}};
                wstrb_o = 4'b0001 << off_i;
            end
            2'b01: begin
                wdata_o = {2{wdata_i[15:0]}};
                wstrb_o = 4'b0011 << off_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (off_i)
            2'd0:    lane_b = rdata_i[7:0];
            2'd1:    lane_b = rdata_i[15:8];
            2'd2:    lane_b = rdata_i[23:16];
            default: lane_b = rdata_i[31:24];
        endcase
        lane_h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_B:    rdata_o = {{24{lane_b[7]}}, lane_b};
            F3_H:    rdata_o = {{16{lane_h[15]}}, lane_h};
            F3_BU:   rdata_o = {24'd0, lane_b};
            F3_HU:   rdata_o = {16'd0, lane_h};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_access_unit : handshaked data-memory stage with core stall   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        done,
    output logic [1:0]  err,
    output logic        dm_req_valid,
    input  logic        dm_req_ready,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_wstrb,
    input  logic        dm_rsp_valid,
    input  logic [31:0] dm_rsp_rdata
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [31:0]       addr_q, wdata_q, load_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [1:0]        err_q;
    logic [TO_W-1:0]   cnt_q;

    logic              w_fault_idle, w_timeout;
    logic [31:0]       w_st_data, w_ld_ext;
    logic [3:0]        w_st_strb;

    assign w_fault_idle = !f3_legal(funct3) || f3_misaligned(funct3, addr[1:0]);
    assign w_timeout    = (cnt_q == TO_LAST);

    mau_align u_align (
        .funct3_i (funct3_q),
        .off_i    (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .rdata_i  (dm_rsp_rdata),
        .wdata_o  (w_st_data),
        .wstrb_o  (w_st_strb),
        .rdata_o  (w_ld_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mem_req) state_d = w_fault_idle ? ST_DONE : ST_REQ;
            ST_REQ: begin
                if (dm_req_ready)   state_d = we_q ? ST_DONE : ST_RESP;
                else if (w_timeout) state_d = ST_DONE;
            end
            ST_RESP: if (dm_rsp_valid || w_timeout) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request fields are latched on acceptance so the bus sees stable values while waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            err_q    <= ERR_OK;
            cnt_q    <= '0;
            load_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_req) begin
                        if (w_fault_idle) begin
                            err_q <= f3_legal(funct3) ? ERR_MISALIGN : ERR_ILLEGAL;
                        end else begin
                            addr_q   <= addr;
                            wdata_q  <= wdata;
                            we_q     <= mem_we;
                            funct3_q <= funct3;
                            err_q    <= ERR_OK;
                            cnt_q    <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    cnt_q <= cnt_q + TO_W'(1);
                    if (!dm_req_ready && w_timeout) err_q <= ERR_TIMEOUT;
                end
                ST_RESP: begin
                    cnt_q <= cnt_q + TO_W'(1);
                    if (dm_rsp_valid)   load_q <= w_ld_ext;
                    else if (w_timeout) err_q  <= ERR_TIMEOUT;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stall        = mem_req && (state_q != ST_DONE);
        done         = (state_q == ST_DONE);
        dm_req_valid = (state_q == ST_REQ);
        dm_we        = dm_req_valid && we_q;
        dm_addr      = dm_req_valid ? {addr_q[31:2], 2'b00} : 32'd0;
        dm_wdata     = dm_we ? w_st_data : 32'd0;
        dm_wstrb     = dm_we ? w_st_strb : 4'b0000;
        err          = err_q;
        load_data    = load_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_access_unit : directed self-checking bench                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we, ready, rsp_valid;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata;
    logic        stall, done, dm_req_valid, dm_we;
    logic [1:0]  err;
    logic [31:0] load_data, dm_addr, dm_wdata;
    logic [3:0]  dm_wstrb;

    logic        t_mem_req, t_ready, t_rsp_valid;
    logic        t_stall, t_done, t_req_valid, t_dm_we;
    logic [1:0]  t_err;
    logic [31:0] t_load_data, t_dm_addr, t_dm_wdata;
    logic [3:0]  t_dm_wstrb;

    int n_pass = 0;
    int n_total = 0;
    int done_cnt = 0;
    int base;

    always #5 clk = ~clk;

    mem_access_unit u_dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .stall(stall), .load_data(load_data), .done(done),
        .err(err), .dm_req_valid(dm_req_valid), .dm_req_ready(ready), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
        .dm_rsp_valid(rsp_valid), .dm_rsp_rdata(rdata)
    );

    mem_access_unit #(.TIMEOUT_CYCLES(4), .TO_W(8)) u_dut_to (
        .clk(clk), .rst(rst), .mem_req(t_mem_req), .mem_we(mem_we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .stall(t_stall), .load_data(t_load_data), .done(t_done),
        .err(t_err), .dm_req_valid(t_req_valid), .dm_req_ready(t_ready), .dm_we(t_dm_we),
        .dm_addr(t_dm_addr), .dm_wdata(t_dm_wdata), .dm_wstrb(t_dm_wstrb),
        .dm_rsp_valid(t_rsp_valid), .dm_rsp_rdata(rdata)
    );

    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic run_lb(input logic [2:0] f3, input logic [31:0] exp, input string tag);
        mem_we = 1'b0; funct3 = f3; addr = 32'h103; ready = 1'b1;
        rdata = 32'h80FF_FF7F; rsp_valid = 1'b0; mem_req = 1'b1;
        tick();
        chk({tag, "_rd_strb"}, 32'(dm_wstrb), 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_wait_stall"}, 32'(stall), 32'h1);
            tick();
        end
        rsp_valid = 1'b1;
        tick();
        chk({tag, "_done"}, 32'(done), 32'h1);
        chk({tag, "_data"}, load_data, exp);
        rsp_valid = 1'b0; mem_req = 1'b0; ready = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0; funct3 = 3'b000; addr = '0;
        wdata = '0; rdata = '0; ready = 1'b0; rsp_valid = 1'b0;
        t_mem_req = 1'b0; t_ready = 1'b0; t_rsp_valid = 1'b0;
        tick(); tick();
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_valid", 32'(dm_req_valid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_load", load_data, 32'h0);
        chk("rst_addr", dm_addr, 32'h0);
        rst = 1'b1;
        tick();

        // SW 0x100
        mem_we = 1'b1; funct3 = 3'b010; addr = 32'h100; wdata = 32'hDEADBEEF;
        ready = 1'b1; mem_req = 1'b1;
        #1;
        chk("sw_idle_stall", 32'(stall), 32'h1);
        chk("sw_idle_valid", 32'(dm_req_valid), 32'h0);
        tick();
        chk("sw_valid", 32'(dm_req_valid), 32'h1);
        chk("sw_strb", 32'(dm_wstrb), 32'hF);
        chk("sw_addr", dm_addr, 32'h100);
        chk("sw_wdata", dm_wdata, 32'hDEADBEEF);
        chk("sw_we", 32'(dm_we), 32'h1);
        chk("sw_req_stall", 32'(stall), 32'h1);
        tick();
        chk("sw_done", 32'(done), 32'h1);
        chk("sw_err", 32'(err), 32'h0);
        chk("sw_done_stall", 32'(stall), 32'h0);
        mem_req = 1'b0; ready = 1'b0;
        tick();
        chk("sw_done_pulse", 32'(done), 32'h0);

        run_lb(3'b000, 32'hFFFF_FF80, "lb");
        run_lb(3'b100, 32'h0000_0080, "lbu");

        // SH 0x202
        mem_we = 1'b1; funct3 = 3'b001; addr = 32'h202; wdata = 32'h1234ABCD;
        ready = 1'b1; mem_req = 1'b1;
        tick();
        chk("sh_wdata", dm_wdata, 32'hABCDABCD);
        chk("sh_strb", 32'(dm_wstrb), 32'hC);
        chk("sh_addr", dm_addr, 32'h200);
        tick();
        chk("sh_done", 32'(done), 32'h1);
        mem_req = 1'b0; ready = 1'b0;
        tick();

        // LH misaligned
        mem_we = 1'b0; funct3 = 3'b001; addr = 32'h201; mem_req = 1'b1;
        #1;
        chk("lh_mis_valid0", 32'(dm_req_valid), 32'h0);
        tick();
        chk("lh_mis_done", 32'(done), 32'h1);
        chk("lh_mis_err", 32'(err), 32'h1);
        chk("lh_mis_valid1", 32'(dm_req_valid), 32'h0);
        mem_req = 1'b0;
        tick();

        // Timeout on the TIMEOUT_CYCLES=4 instance
        mem_we = 1'b0; funct3 = 3'b010; addr = 32'h300; t_mem_req = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to_req_valid", 32'(t_req_valid), 32'h1);
            chk("to_no_done", 32'(t_done), 32'h0);
            tick();
        end
        chk("to_done", 32'(t_done), 32'h1);
        chk("to_err", 32'(t_err), 32'h2);
        t_mem_req = 1'b0;
        tick();
        t_rsp_valid = 1'b1;
        tick();
        chk("to_stale_done", 32'(t_done), 32'h0);
        chk("to_stale_valid", 32'(t_req_valid), 32'h0);
        t_rsp_valid = 1'b0;
        tick();
        chk("to_stale_done2", 32'(t_done), 32'h0);

        // Illegal funct3
        mem_we = 1'b0; funct3 = 3'b011; addr = 32'h0; mem_req = 1'b1;
        tick();
        chk("ill_done", 32'(done), 32'h1);
        chk("ill_err", 32'(err), 32'h3);
        chk("ill_valid", 32'(dm_req_valid), 32'h0);
        mem_req = 1'b0;
        tick();

        // Reset while in RESP
        funct3 = 3'b010; addr = 32'h40; ready = 1'b1; mem_req = 1'b1;
        tick();
        tick();
        chk("rr_resp_stall", 32'(stall), 32'h1);
        rst = 1'b0; mem_req = 1'b0; ready = 1'b0;
        #1;
        chk("rr_valid", 32'(dm_req_valid), 32'h0);
        chk("rr_done", 32'(done), 32'h0);
        chk("rr_load", load_data, 32'h0);
        chk("rr_stall", 32'(stall), 32'h0);
        chk("rr_addr", dm_addr, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        chk("rr_no_done", 32'(done), 32'h0);
        addr = 32'h44; ready = 1'b1; rsp_valid = 1'b1; rdata = 32'hCAFEF00D; mem_req = 1'b1;
        tick();
        tick();
        tick();
        chk("rr_lw_done", 32'(done), 32'h1);
        chk("rr_lw_data", load_data, 32'hCAFEF00D);
        chk("rr_lw_err", 32'(err), 32'h0);
        mem_req = 1'b0; rsp_valid = 1'b0; ready = 1'b0;
        tick();

        // Back-to-back LW then SW with two-cycle ready stalls
        base = done_cnt;
        mem_we = 1'b0; funct3 = 3'b010; addr = 32'h80; rdata = 32'h11223344; mem_req = 1'b1;
        tick();
        chk("bb_lw_valid_a", 32'(dm_req_valid), 32'h1);
        chk("bb_lw_addr_a", dm_addr, 32'h80);
        tick();
        chk("bb_lw_valid_b", 32'(dm_req_valid), 32'h1);
        chk("bb_lw_addr_b", dm_addr, 32'h80);
        chk("bb_lw_strb", 32'(dm_wstrb), 32'h0);
        ready = 1'b1;
        tick();
        ready = 1'b0; rsp_valid = 1'b1;
        tick();
        chk("bb_lw_done", 32'(done), 32'h1);
        chk("bb_lw_data", load_data, 32'h11223344);
        mem_we = 1'b1; addr = 32'h84; wdata = 32'h55667788; rsp_valid = 1'b0;
        tick();
        tick();
        chk("bb_sw_valid_a", 32'(dm_req_valid), 32'h1);
        chk("bb_sw_addr_a", dm_addr, 32'h84);
        chk("bb_sw_wdata_a", dm_wdata, 32'h55667788);
        tick();
        chk("bb_sw_valid_b", 32'(dm_req_valid), 32'h1);
        chk("bb_sw_addr_b", dm_addr, 32'h84);
        ready = 1'b1;
        tick();
        chk("bb_sw_done", 32'(done), 32'h1);
        mem_req = 1'b0; ready = 1'b0;
        tick();
        tick();
        chk("bb_done_count", 32'(done_cnt - base), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
